// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and counter widths for the round sequencer.
// The ST_* state values are also consumed by draw_background, uart_top and
// ran_num_gen, so their encoding must not change.
package game_pkg;

   localparam int unsigned STATE_W     = 2;
   localparam int unsigned FRAME_CNT_W = 7;   // frames within one second (FRAMES_PER_SEC <= 127)
   localparam int unsigned DUCK_CNT_W  = 8;   // frames since last duck respawn (<= 255)
   localparam int unsigned SEC_CNT_W   = 6;   // seconds spent in WAIT / SCORE (<= 63)
   localparam int unsigned TIME_W      = 6;   // round seconds remaining (<= 63)

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_GAME  = 2'd2,
      ST_SCORE = 2'd3
   } game_state_e;

endpackage

// File: rtl/game_round_ctl_if.sv
// game_round_ctl_if: event inputs and sequencing outputs of the round controller.
//   vsync_in, play_clicked, uart_start, duck_hit, mouse_right : sources -> controller
//   state, round_start, respawn, game_over, time_left        : controller -> consumers
// master = the surrounding system (drives events), slave = game_round_ctl.
interface game_round_ctl_if;
   import game_pkg::*;

   logic                vsync_in;
   logic                play_clicked;
   logic                uart_start;
   logic                duck_hit;
   logic                mouse_right;
   logic [STATE_W-1:0]  state;
   logic                round_start;
   logic                respawn;
   logic                game_over;
   logic [TIME_W-1:0]   time_left;

   modport master (
      output vsync_in, play_clicked, uart_start, duck_hit, mouse_right,
      input  state, round_start, respawn, game_over, time_left
   );

   modport slave (
      input  vsync_in, play_clicked, uart_start, duck_hit, mouse_right,
      output state, round_start, respawn, game_over, time_left
   );

endinterface

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: vsync rising-edge detector and frame prescaler.
//   clk, rst_n  : clock, async active-low reset
//   vsync_in    : raw vsync pulse from vga_timing
//   en          : count frames (controller is out of IDLE)
//   clr         : controller state changes this cycle; restart the second
//   frame_edge  : 1-cycle pulse, one cycle after each accepted vsync rise
//   sec_tick    : 1-cycle pulse on every FRAMES_PER_SEC-th accepted rise
// A rise that coincides with clr or !en is dropped from both outputs so the
// duck schedule and the second count always agree on which frames belong
// to the current state.
module sec_tick_gen
   import game_pkg::*;
#(
   parameter int unsigned FRAMES_PER_SEC = 70
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vsync_in,
   input  logic en,
   input  logic clr,
   output logic frame_edge,
   output logic sec_tick
);

   localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAMES_PER_SEC - 1);

   logic                   vsync_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic                   rise_c;
   logic                   take_c;

   assign rise_c = vsync_in & ~vsync_q;
   assign take_c = rise_c & en & ~clr;

   // Edge register, prescaler and registered pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q     <= 1'b0;
         frame_cnt_q <= '0;
         frame_edge  <= 1'b0;
         sec_tick    <= 1'b0;
      end else begin
         vsync_q    <= vsync_in;
         frame_edge <= take_c;
         sec_tick   <= 1'b0;
         if (clr || !en) begin
            frame_cnt_q <= '0;
         end else if (rise_c) begin
            if (frame_cnt_q == FRAME_LAST) begin
               frame_cnt_q <= '0;
               sec_tick    <= 1'b1;
            end else begin
               frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/game_round_ctl.sv
// game_round_ctl: IDLE/WAIT/GAME/SCORE round sequencer for the duck game.
//   pclk, rst_n : pixel clock, async active-low reset
//   bus (slave) : vsync_in, play_clicked, uart_start, duck_hit, mouse_right in;
//                 state, round_start, respawn, game_over, time_left out (all registered)
// Time base is vsync frames; sec_tick_gen turns them into seconds.
module game_round_ctl
   import game_pkg::*;
#(
   parameter int unsigned FRAMES_PER_SEC      = 70,
   parameter int unsigned ROUND_SEC           = 30,
   parameter int unsigned DUCK_TIMEOUT_FRAMES = 105,
   parameter int unsigned WAIT_TIMEOUT_SEC    = 20,
   parameter int unsigned SCORE_HOLD_SEC      = 10
) (
   input  logic              pclk,
   input  logic              rst_n,
   game_round_ctl_if.slave   bus
);

   localparam logic [DUCK_CNT_W-1:0] DUCK_LAST  = DUCK_CNT_W'(DUCK_TIMEOUT_FRAMES - 1);
   localparam logic [SEC_CNT_W-1:0]  WAIT_LAST  = SEC_CNT_W'(WAIT_TIMEOUT_SEC - 1);
   localparam logic [SEC_CNT_W-1:0]  HOLD_LAST  = SEC_CNT_W'(SCORE_HOLD_SEC - 1);
   localparam logic [TIME_W-1:0]     ROUND_TIME = TIME_W'(ROUND_SEC);

   game_state_e            state_q, state_d;
   logic                   opp_q, opp_d;
   logic [TIME_W-1:0]      time_q, time_d;
   logic [DUCK_CNT_W-1:0]  duck_q, duck_d;
   logic [SEC_CNT_W-1:0]   sec_q, sec_d;
   logic                   round_start_q, round_start_d;
   logic                   respawn_q, respawn_d;
   logic                   game_over_q, game_over_d;

   logic                   frame_edge;
   logic                   sec_tick;
   logic                   opp_any_c;
   logic                   tick_en_c;
   logic                   tick_clr_c;

   assign opp_any_c  = opp_q | bus.uart_start;
   assign tick_en_c  = (state_q != ST_IDLE);
   assign tick_clr_c = (state_d != state_q);

   // Frame/second time base.
   sec_tick_gen #(
      .FRAMES_PER_SEC (FRAMES_PER_SEC)
   ) u_sec_tick_gen (
      .clk        (pclk),
      .rst_n      (rst_n),
      .vsync_in   (bus.vsync_in),
      .en         (tick_en_c),
      .clr        (tick_clr_c),
      .frame_edge (frame_edge),
      .sec_tick   (sec_tick)
   );

   // State and datapath registers.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         opp_q         <= 1'b0;
         time_q        <= '0;
         duck_q        <= '0;
         sec_q         <= '0;
         round_start_q <= 1'b0;
         respawn_q     <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         opp_q         <= opp_d;
         time_q        <= time_d;
         duck_q        <= duck_d;
         sec_q         <= sec_d;
         round_start_q <= round_start_d;
         respawn_q     <= respawn_d;
         game_over_q   <= game_over_d;
      end
   end

   // Next-state, countdown, opponent latch and duck schedule.
   always_comb begin
      state_d       = state_q;
      opp_d         = opp_q;
      time_d        = time_q;
      duck_d        = duck_q;
      sec_d         = sec_q;
      round_start_d = 1'b0;
      respawn_d     = 1'b0;
      game_over_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.play_clicked) begin
               state_d = opp_any_c ? ST_GAME : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (opp_any_c) begin
               state_d = ST_GAME;
            end else if (bus.mouse_right) begin
               state_d = ST_IDLE;
            end else if (sec_tick) begin
               if (sec_q == WAIT_LAST) state_d = ST_IDLE;
               else                    sec_d   = sec_q + SEC_CNT_W'(1);
            end
         end
         ST_GAME: begin
            // Abort wins over the final tick, so no game_over on abort.
            if (bus.mouse_right) begin
               state_d = ST_IDLE;
            end else if (sec_tick) begin
               if (time_q <= TIME_W'(1)) begin
                  state_d     = ST_SCORE;
                  game_over_d = 1'b1;
                  time_d      = '0;
               end else begin
                  time_d = time_q - TIME_W'(1);
               end
            end
         end
         ST_SCORE: begin
            if (bus.mouse_right) begin
               state_d = ST_IDLE;
            end else if (sec_tick) begin
               if (sec_q == HOLD_LAST) state_d = ST_IDLE;
               else                    sec_d   = sec_q + SEC_CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_q == ST_IDLE || state_q == ST_WAIT) && bus.uart_start) begin
         opp_d = 1'b1;
      end

      // Entry actions; a leaving GAME cycle never issues a respawn.
      if (state_d != state_q) begin
         sec_d  = '0;
         duck_d = '0;
         if (state_d == ST_GAME) begin
            time_d        = ROUND_TIME;
            round_start_d = 1'b1;
            respawn_d     = 1'b1;
            opp_d         = 1'b0;
         end else if (state_d == ST_IDLE) begin
            time_d = '0;
            opp_d  = 1'b0;
         end
      end else if (state_q == ST_GAME) begin
         if (bus.duck_hit || (frame_edge && duck_q == DUCK_LAST)) begin
            respawn_d = 1'b1;
            duck_d    = '0;
         end else if (frame_edge) begin
            duck_d = duck_q + DUCK_CNT_W'(1);
         end
      end
   end

   assign bus.state       = state_q;
   assign bus.round_start = round_start_q;
   assign bus.respawn     = respawn_q;
   assign bus.game_over   = game_over_q;
   assign bus.time_left   = time_q;

endmodule

// File: doc/game_round_ctl.md
# game_round_ctl

Round sequencer for the duck-shooting game: owns the IDLE/WAIT/GAME/SCORE state, the opponent handshake, the round countdown and the duck respawn schedule. Sits between the input sources (click_ctl, click_image_ctl, UART start flag, mouse buttons) and the consumers (RGB mux, ran_num_gen, score_counter, uart_top). It takes over sequencing from the present state selector. Time is measured in frames from the vga_timing vsync, so it needs no wall-clock divider.

## Interface
Parameters:
- FRAMES_PER_SEC, 70, vsync rising edges per second (1..127)
- ROUND_SEC, 30, round length in seconds (1..63)
- DUCK_TIMEOUT_FRAMES, 105, frames before an unhit duck is relocated (1..255)
- WAIT_TIMEOUT_SEC, 20, maximum time in WAIT without an opponent (1..63)
- SCORE_HOLD_SEC, 10, time the SCORE screen is held (1..63)

Ports:
- pclk  in  1  pixel clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- vsync_in  in  1  vsync from vga_timing (active-high pulse)
- play_clicked  in  1  1-cycle pulse from the play button click_ctl
- uart_start  in  1  opponent-ready flag from uart_top; level or pulse
- duck_hit  in  1  1-cycle pulse from click_image_ctl
- mouse_right  in  1  abort/leave request, synchronised level
- state  out  2  0 IDLE, 1 WAIT, 2 GAME, 3 SCORE
- round_start  out  1  1-cycle pulse on GAME entry
- respawn  out  1  1-cycle pulse requesting a new duck position
- game_over  out  1  1-cycle pulse on normal GAME→SCORE
- time_left  out  6  seconds remaining; valid in GAME and SCORE

## Operation
- Reset values: state=IDLE, time_left=0, all pulses 0, opp_ready=0, all counters 0.
- sec_tick: a 1-cycle pulse on every FRAMES_PER_SEC-th vsync rising edge. It counts only while state is WAIT, GAME or SCORE. Frame counters clear on every state change.
- opp_ready: set by uart_start while in IDLE or WAIT. Cleared on entry to GAME or IDLE.
- IDLE:
  - play_clicked with opp_ready or uart_start → GAME.
  - Otherwise play_clicked → WAIT.
- WAIT:
  - opp_ready or uart_start → GAME.
  - mouse_right → IDLE.
  - After WAIT_TIMEOUT_SEC sec_ticks → IDLE.
- GAME entry: time_left=ROUND_SEC, round_start=1, respawn=1 and the duck frame counter is cleared.
- GAME operation:
  - Each sec_tick decrements time_left.
  - When the tick takes time_left from 1 to 0: → SCORE with game_over=1.
  - mouse_right → IDLE with no game_over. Abort has priority over expiry in the same cycle.
- Duck schedule (GAME only): the duck frame counter increments on each vsync edge.
  - duck_hit or counter==DUCK_TIMEOUT_FRAMES-1 at an edge: respawn=1 and the counter clears.
  - Hit and timeout in the same cycle produce one pulse.
  - No respawn is generated in the GAME→SCORE transition cycle or afterwards.
- SCORE: time_left holds 0. After SCORE_HOLD_SEC sec_ticks, or on mouse_right → IDLE.
- Events presented outside their state are ignored, except uart_start, which latches as above.
- Reset during any state returns to IDLE immediately; no pulses are emitted.

## Timing
- All outputs are registered. state changes on the pclk edge after the qualifying input cycle, which is 1-cycle latency.
- round_start, game_over and the entry respawn assert in the same cycle that state first shows the new value.
- vsync edge detect adds 1 cycle: respawn from timeout appears 2 cycles after the vsync rising edge. respawn from duck_hit appears 1 cycle after the hit.
- time_left updates in the cycle after sec_tick.
- Arithmetic is unsigned. Counters never wrap through zero; terminal-count compare, then clear.

## Structure
- Package game_pkg holds:
  - state localparams ST_IDLE, ST_WAIT, ST_GAME, ST_SCORE (2 bits), shared with draw_background, uart_top and ran_num_gen;
  - counter width constants.
- Sub-module sec_tick_gen contains the vsync rising-edge detector, the frame prescaler, an enable input and a clear input. It outputs frame_edge and sec_tick.
- The top level contains the FSM, opp_ready, time_left and the duck counter (about 200 lines).

## Test plan
Bench parameters: FRAMES_PER_SEC=4, ROUND_SEC=3, DUCK_TIMEOUT_FRAMES=5, WAIT_TIMEOUT_SEC=2, SCORE_HOLD_SEC=2.

- play_clicked with no opponent, then uart_start 10 cycles later → state 0→1→2; round_start and respawn each high exactly one cycle; time_left=3.
- uart_start pulse in IDLE, then play_clicked → state goes directly 0→2; WAIT never seen.
- GAME with no hits over 12 vsync edges → time_left 3,2,1,0; game_over on the 12th edge; respawn at edges 5 and 10; state=3; 8 more edges → state=0.
- duck_hit at the same cycle a timeout respawn is due → exactly one respawn pulse; next timeout 5 edges later.
- WAIT with no opponent for 8 edges → IDLE; mouse_right in the same cycle as the final GAME tick → IDLE with no game_over.
- rst_n asserted mid-GAME, asynchronously between pclk edges → state=0 and time_left=0 immediately; the next play_clicked restarts from WAIT.
